lr_sc_reservation_unit: RTL and testbench
=========================================

Name: lr_sc_reservation_unit

Overview:
Per-hart load-reserved/store-conditional reservation tracker for the barrel-threaded core. It sits directly downstream of the control unit and consumes its LR marker (res_station_valid), SC marker (store_cond) and ordinary store enable, together with the ALU-computed address and the issuing hart ID. It records reservations on LR, resolves SC success or failure, and gates the SC memory write. It also returns the SC rd value: 0 on success, 1 on failure.

Parameters:
NUM_THREADS, 16, number of hardware harts; must be a power of two and at least 2.
ADDR_WIDTH, 32, byte address width.
GRANULE_LSB, 2, log2 of the reservation granule in bytes. Addresses compare on [ADDR_WIDTH-1:GRANULE_LSB].

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
i_valid  in  1  instruction in this stage is live (not bubble/squashed).
i_thread_id  in  $clog2(NUM_THREADS)  issuing hart.
i_res_station_valid  in  1  LR in this stage.
i_store_cond  in  1  SC in this stage.
i_mem_we  in  1  ordinary store in this stage.
i_addr  in  ADDR_WIDTH  effective byte address.
o_sc_valid  out  1  SC result valid; registered.
o_sc_thread_id  out  $clog2(NUM_THREADS)  hart owning o_sc_result.
o_sc_result  out  32  rd value for SC: 0 = success, 1 = fail.
o_sc_mem_we  out  1  write enable for the SC data write; registered, aligned with o_sc_valid.
o_res_valid_vec  out  NUM_THREADS  per-hart reservation valid bits (debug/verification).

Behaviour:
- Reset: all reservation valid bits = 0 and all addresses = 0. o_sc_valid = 0, o_sc_thread_id = 0, o_sc_result = 0, o_sc_mem_we = 0.
- State: for each hart, res_valid[t] and res_addr[t], the granule-truncated address.
- All ops qualify on i_valid. When i_valid = 0, no state change occurs and o_sc_valid/o_sc_mem_we deassert next cycle.
- At most one of LR, SC or ordinary store is asserted per cycle. If more than one is asserted, priority is SC > store > LR; the lower-priority ops are ignored.
- LR (cycle N):
  - res_valid[tid] <= 1 and res_addr[tid] <= i_addr granule.
  - Any prior reservation of the same hart is overwritten.
  - Other harts are unaffected.
- SC (cycle N):
  - hit = res_valid[tid] && res_addr[tid] == i_addr granule.
  - At N+1: o_sc_valid = 1, o_sc_thread_id = tid, o_sc_result = hit ? 0 : 1, o_sc_mem_we = hit.
  - res_valid[tid] <= 0 regardless of outcome.
  - On hit, every other hart t whose res_valid[t] && res_addr[t] matches also gets res_valid[t] <= 0.
- Ordinary store (cycle N): every hart t, including the issuing hart, whose valid reservation matches the store granule gets res_valid[t] <= 0. No output pulse.
- Latency: SC result is exactly 1 cycle. Outputs are single-cycle pulses; there is no backpressure.
- Back-to-back ops:
  - An SC in N+1 observes state updated by the op in N. Example: LR in N, SC same hart and granule in N+1 → success.
  - A store in N from another hart to the same granule, followed by SC in N+1 → fail.
- Invalidation is granule-exact. Differing bits below GRANULE_LSB still match.
- Reset asserted mid-stream: all reservations are cleared next edge. A pending o_sc_valid is forced to 0 in the reset cycle's output.
- The thread ID is treated as a full index; no range check is needed because NUM_THREADS is a power of two.

Test Plan:
- Reset, then SC hart 3 addr 0x100 → next cycle o_sc_valid = 1, o_sc_thread_id = 3, o_sc_result = 1, o_sc_mem_we = 0; o_res_valid_vec = 0.
- LR hart 2 0x200, then SC hart 2 0x200 → o_sc_result = 0, o_sc_mem_we = 1. A second SC hart 2 0x200 → result 1 (reservation consumed).
- LR hart 1 0x300 and LR hart 5 0x300; store hart 7 0x302 → o_res_valid_vec bits 1 and 5 clear. SC hart 1 0x300 → fail.
- LR hart 4 0x400, LR hart 6 0x400; SC hart 4 0x400 succeeds → bit 6 also cleared; SC hart 6 → fail.
- LR hart 0 0x500, SC hart 0 0x504 → fail and bit 0 cleared. LR hart 0 0x500, store 0x600 → bit 0 stays set.
- LR hart 9 0x700, then reset, then SC hart 9 0x700 → fail. Also check the i_valid = 0 LR pulse leaves o_res_valid_vec unchanged.

Source files
------------

// File: rtl/lr_sc_reservation_unit.sv
// Per-hart LR/SC reservation tracker: records LR reservations, resolves SC, gates the SC write.
// SC result, thread ID and write enable are registered one cycle after issue; single-cycle pulses, no backpressure.
module lr_sc_reservation_unit #(
    parameter int NUM_THREADS = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int GRANULE_LSB = 2,
    localparam int TID_W      = $clog2(NUM_THREADS),
    localparam int GRAN_W     = ADDR_WIDTH - GRANULE_LSB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [TID_W-1:0]       i_thread_id,
    input  logic                   i_res_station_valid,
    input  logic                   i_store_cond,
    input  logic                   i_mem_we,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   o_sc_valid,
    output logic [TID_W-1:0]       o_sc_thread_id,
    output logic [31:0]            o_sc_result,
    output logic                   o_sc_mem_we,
    output logic [NUM_THREADS-1:0] o_res_valid_vec
);

    logic [NUM_THREADS-1:0] r_res_valid;
    logic [GRAN_W-1:0]      r_res_addr [NUM_THREADS];

    logic [GRAN_W-1:0]      w_granule;
    logic                   w_is_sc;
    logic                   w_is_st;
    logic                   w_is_lr;
    logic [NUM_THREADS-1:0] w_match;
    logic                   w_hit;
    logic [NUM_THREADS-1:0] w_res_valid_nxt;

    assign w_granule = i_addr[ADDR_WIDTH-1:GRANULE_LSB];

    // Priority SC > store > LR when markers collide.
    assign w_is_sc = i_valid & i_store_cond;
    assign w_is_st = i_valid & i_mem_we & ~i_store_cond;
    assign w_is_lr = i_valid & i_res_station_valid & ~i_store_cond & ~i_mem_we;

    always_comb begin
        w_match = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_match[t] = r_res_valid[t] && (r_res_addr[t] == w_granule);
        end
    end

    assign w_hit = w_match[i_thread_id];

    always_comb begin
        w_res_valid_nxt = r_res_valid;
        if (w_is_sc) begin
            if (w_hit) begin
                w_res_valid_nxt = r_res_valid & ~w_match;
            end
            w_res_valid_nxt[i_thread_id] = 1'b0;
        end else if (w_is_st) begin
            w_res_valid_nxt = r_res_valid & ~w_match;
        end else if (w_is_lr) begin
            w_res_valid_nxt[i_thread_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_res_addr[t] <= '0;
            end
            o_sc_valid     <= 1'b0;
            o_sc_thread_id <= '0;
            o_sc_result    <= '0;
            o_sc_mem_we    <= 1'b0;
        end else begin
            r_res_valid <= w_res_valid_nxt;
            if (w_is_lr) begin
                r_res_addr[i_thread_id] <= w_granule;
            end
            o_sc_valid  <= w_is_sc;
            o_sc_mem_we <= w_is_sc & w_hit;
            if (w_is_sc) begin
                o_sc_thread_id <= i_thread_id;
                o_sc_result    <= {31'd0, ~w_hit};
            end
        end
    end

    assign o_res_valid_vec = r_res_valid;

endmodule

// File: tb/tb_lr_sc_reservation_unit.sv
// Directed bench for lr_sc_reservation_unit with hand-computed expectations.
module tb_lr_sc_reservation_unit;

    localparam int NT = 16;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [3:0]  i_thread_id;
    logic        i_res_station_valid;
    logic        i_store_cond;
    logic        i_mem_we;
    logic [31:0] i_addr;
    logic        o_sc_valid;
    logic [3:0]  o_sc_thread_id;
    logic [31:0] o_sc_result;
    logic        o_sc_mem_we;
    logic [NT-1:0] o_res_valid_vec;

    int n_tests = 0;
    int n_fail  = 0;

    lr_sc_reservation_unit #(.NUM_THREADS(NT), .ADDR_WIDTH(32), .GRANULE_LSB(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_valid             (i_valid),
        .i_thread_id         (i_thread_id),
        .i_res_station_valid (i_res_station_valid),
        .i_store_cond        (i_store_cond),
        .i_mem_we            (i_mem_we),
        .i_addr              (i_addr),
        .o_sc_valid          (o_sc_valid),
        .o_sc_thread_id      (o_sc_thread_id),
        .o_sc_result         (o_sc_result),
        .o_sc_mem_we         (o_sc_mem_we),
        .o_res_valid_vec     (o_res_valid_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One op for one cycle; outputs sampled 1 time unit after the edge, inputs then idled.
    task automatic op(input logic v, input int tid, input logic lr, input logic sc,
                      input logic we, input logic [31:0] addr);
        @(negedge clk);
        i_valid             = v;
        i_thread_id         = tid[3:0];
        i_res_station_valid = lr;
        i_store_cond        = sc;
        i_mem_we            = we;
        i_addr              = addr;
        @(posedge clk);
        #1;
        i_valid             = 1'b0;
        i_res_station_valid = 1'b0;
        i_store_cond        = 1'b0;
        i_mem_we            = 1'b0;
    endtask

    task automatic lr(input int tid, input logic [31:0] a); op(1'b1, tid, 1'b1, 1'b0, 1'b0, a); endtask
    task automatic sc(input int tid, input logic [31:0] a); op(1'b1, tid, 1'b0, 1'b1, 1'b0, a); endtask
    task automatic st(input int tid, input logic [31:0] a); op(1'b1, tid, 1'b0, 1'b0, 1'b1, a); endtask

    task automatic check_sc(input string tag, input int tid, input logic ok);
        check({tag, ".vld"}, {31'd0, o_sc_valid}, 32'd1);
        check({tag, ".tid"}, {28'd0, o_sc_thread_id}, tid);
        check({tag, ".res"}, o_sc_result, ok ? 32'd0 : 32'd1);
        check({tag, ".we"},  {31'd0, o_sc_mem_we}, {31'd0, ok});
    endtask

    initial begin
        reset = 1'b1;
        i_valid = 1'b0; i_thread_id = '0; i_res_station_valid = 1'b0;
        i_store_cond = 1'b0; i_mem_we = 1'b0; i_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.vec", {16'd0, o_res_valid_vec}, 32'd0);
        check("rst.vld", {31'd0, o_sc_valid}, 32'd0);
        check("rst.tid", {28'd0, o_sc_thread_id}, 32'd0);
        check("rst.res", o_sc_result, 32'd0);
        check("rst.we",  {31'd0, o_sc_mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        sc(3, 32'h100);
        check_sc("sc_norsv", 3, 1'b0);
        check("sc_norsv.vec", {16'd0, o_res_valid_vec}, 32'd0);
        op(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("idle.vld", {31'd0, o_sc_valid}, 32'd0);
        check("idle.we",  {31'd0, o_sc_mem_we}, 32'd0);

        lr(2, 32'h200);
        check("lr2.vec", {16'd0, o_res_valid_vec}, 32'h0004);
        sc(2, 32'h200);
        check_sc("sc2_hit", 2, 1'b1);
        check("sc2_hit.vec", {16'd0, o_res_valid_vec}, 32'd0);
        sc(2, 32'h200);
        check_sc("sc2_again", 2, 1'b0);

        lr(1, 32'h300);
        lr(5, 32'h300);
        check("lr15.vec", {16'd0, o_res_valid_vec}, 32'h0022);
        st(7, 32'h302);
        check("st7.vec", {16'd0, o_res_valid_vec}, 32'd0);
        check("st7.vld", {31'd0, o_sc_valid}, 32'd0);
        sc(1, 32'h300);
        check_sc("sc1_after_st", 1, 1'b0);

        lr(4, 32'h400);
        lr(6, 32'h400);
        check("lr46.vec", {16'd0, o_res_valid_vec}, 32'h0050);
        sc(4, 32'h400);
        check_sc("sc4_hit", 4, 1'b1);
        check("sc4_hit.vec", {16'd0, o_res_valid_vec}, 32'd0);
        sc(6, 32'h400);
        check_sc("sc6_lost", 6, 1'b0);

        lr(0, 32'h500);
        sc(0, 32'h504);
        check_sc("sc0_wrong_gran", 0, 1'b0);
        check("sc0_wrong_gran.vec", {16'd0, o_res_valid_vec}, 32'd0);
        lr(0, 32'h500);
        st(3, 32'h600);
        check("st_other_gran.vec", {16'd0, o_res_valid_vec}, 32'h0001);
        st(3, 32'h501);
        check("st_subgran.vec", {16'd0, o_res_valid_vec}, 32'd0);

        // Hart 3 SC with a rival LR on 0x580 from hart 8: a hit must kill only matching harts.
        lr(8, 32'h580);
        lr(3, 32'h500);
        sc(3, 32'h503);
        check_sc("sc3_subgran", 3, 1'b1);
        check("sc3_subgran.vec", {16'd0, o_res_valid_vec}, 32'h0100);
        sc(8, 32'h580);
        check_sc("sc8_kept", 8, 1'b1);

        op(1'b1, 10, 1'b1, 1'b1, 1'b0, 32'h800);
        check_sc("prio_sc_lr", 10, 1'b0);
        check("prio_sc_lr.vec", {16'd0, o_res_valid_vec}, 32'd0);
        op(1'b1, 11, 1'b1, 1'b0, 1'b1, 32'h900);
        check("prio_st_lr.vec", {16'd0, o_res_valid_vec}, 32'd0);
        check("prio_st_lr.vld", {31'd0, o_sc_valid}, 32'd0);

        op(1'b0, 9, 1'b1, 1'b0, 1'b0, 32'h700);
        check("lr_invalid.vec", {16'd0, o_res_valid_vec}, 32'd0);
        lr(9, 32'h700);
        check("lr9.vec", {16'd0, o_res_valid_vec}, 32'h0200);
        @(negedge clk);
        reset = 1'b1;
        i_valid = 1'b1; i_thread_id = 4'd9; i_store_cond = 1'b1; i_addr = 32'h700;
        @(posedge clk);
        #1;
        check("rst_mid.vec", {16'd0, o_res_valid_vec}, 32'd0);
        check("rst_mid.vld", {31'd0, o_sc_valid}, 32'd0);
        check("rst_mid.we",  {31'd0, o_sc_mem_we}, 32'd0);
        i_valid = 1'b0; i_store_cond = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        sc(9, 32'h700);
        check_sc("sc9_after_rst", 9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
